// File: rtl/i_mem_loader_if.sv
// Byte-stream input and instruction-memory write port of the instruction memory loader.
// master: byte source / memory side; slave: the loader.
interface i_mem_loader_if #(
  parameter int unsigned ISIZE     = 16,
  parameter int unsigned MEM_SPACE = 8
);
  logic [7:0]           byte_in;
  logic                 byte_valid;
  logic                 byte_last;
  logic                 byte_ready;
  logic                 wr_en;
  logic [MEM_SPACE-1:0] wr_addr;
  logic [ISIZE-1:0]     wr_data;

  modport master (
    output byte_in, byte_valid, byte_last,
    input  byte_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  byte_in, byte_valid, byte_last,
    output byte_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/i_mem_loader.sv
// Packs a big-endian byte stream into instructions, writes them from address 0,
// zero-fills the rest of the memory and then releases the core.
module i_mem_loader #(
  parameter int unsigned ISIZE     = 16,
  parameter int unsigned MEM_SPACE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  i_mem_loader_if.slave        bus,
  output logic                 cpu_hold,
  output logic                 load_done,
  output logic [MEM_SPACE:0]   word_count,
  output logic                 err_odd,
  output logic                 err_ovf
);

  localparam logic [MEM_SPACE-1:0] ADDR_MAX = '1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HI   = 3'd1,
    LO   = 3'd2,
    WR   = 3'd3,
    FILL = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t               state, state_n;
  logic [MEM_SPACE-1:0] addr, addr_n;
  logic [7:0]           data_hi;
  logic                 last_q;
  logic                 byte_ready_q;
  logic                 wr_en_q;
  logic [ISIZE-1:0]     wr_data_q;
  logic                 xfer;
  logic                 addr_full;
  logic                 start_ok;

  assign bus.byte_ready = byte_ready_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = addr;
  assign bus.wr_data    = wr_data_q;

  // Next state and next write address; the address only advances when leaving WR or per FILL write.
  always_comb begin
    state_n   = state;
    addr_n    = addr;
    xfer      = bus.byte_valid && byte_ready_q;
    addr_full = (addr == ADDR_MAX);
    start_ok  = start && ((state == IDLE) || (state == DONE));
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = HI;
          addr_n  = '0;
        end
      end
      HI: begin
        if (xfer) state_n = bus.byte_last ? FILL : LO;
      end
      LO: begin
        if (xfer) state_n = WR;
      end
      WR: begin
        if (addr_full) begin
          state_n = DONE;
        end else begin
          addr_n  = addr + MEM_SPACE'(1);
          state_n = last_q ? FILL : HI;
        end
      end
      FILL: begin
        if (addr_full) state_n = DONE;
        else           addr_n  = addr + MEM_SPACE'(1);
      end
      default: state_n = IDLE;
    endcase
  end

  // State, datapath and all outputs registered; handshake/strobe outputs follow the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      addr         <= '0;
      data_hi      <= '0;
      last_q       <= 1'b0;
      byte_ready_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_data_q    <= '0;
      cpu_hold     <= 1'b1;
      load_done    <= 1'b0;
      word_count   <= '0;
      err_odd      <= 1'b0;
      err_ovf      <= 1'b0;
    end else begin
      state        <= state_n;
      addr         <= addr_n;
      byte_ready_q <= (state_n == HI) || (state_n == LO);
      wr_en_q      <= (state_n == WR) || (state_n == FILL);
      cpu_hold     <= (state_n != DONE);
      load_done    <= (state_n == DONE);
      wr_data_q    <= ((state == LO) && xfer) ? ISIZE'({data_hi, bus.byte_in}) : '0;

      if ((state == HI) && xfer) data_hi <= bus.byte_in;
      if ((state == LO) && xfer) last_q  <= bus.byte_last;

      if (start_ok) begin
        word_count <= '0;
        err_odd    <= 1'b0;
        err_ovf    <= 1'b0;
      end
      if (state == WR) word_count <= word_count + (MEM_SPACE + 1)'(1);
      if ((state == HI) && xfer && bus.byte_last) err_odd <= 1'b1;
      // Filling the last location without seeing byte_last means the image did not fit.
      if ((state == WR) && addr_full && !last_q) err_ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_i_mem_loader.sv
// Scoreboard bench for i_mem_loader: expected writes queued as bytes are sent,
// observed writes captured on the falling edge and compared in order.
module tb_i_mem_loader;

  localparam int unsigned ISIZE     = 16;
  localparam int unsigned MEM_SPACE = 8;
  localparam int unsigned DEPTH     = 256;

  logic                 clk   = 1'b0;
  logic                 rst   = 1'b0;
  logic                 start = 1'b0;
  logic                 cpu_hold;
  logic                 load_done;
  logic [MEM_SPACE:0]   word_count;
  logic                 err_odd;
  logic                 err_ovf;

  i_mem_loader_if #(.ISIZE(ISIZE), .MEM_SPACE(MEM_SPACE)) bus ();

  i_mem_loader #(.ISIZE(ISIZE), .MEM_SPACE(MEM_SPACE)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bus        (bus),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .word_count (word_count),
    .err_odd    (err_odd),
    .err_ovf    (err_ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [MEM_SPACE-1:0] addr;
    logic [ISIZE-1:0]     data;
  } wr_t;

  wr_t exp_q[$];
  wr_t obs_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  // Capture every write strobe
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) obs_q.push_back({bus.wr_addr, bus.wr_data});
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Offer one byte; ok reports whether it was accepted within the bound.
  task automatic send_byte(input logic [7:0] b, input logic l, input int gap, output bit ok);
    ok = 1'b0;
    repeat (gap) step();
    bus.byte_in    = b;
    bus.byte_last  = l;
    bus.byte_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = bus.byte_ready;
      @(posedge clk);
      #1;
    end
    bus.byte_valid = 1'b0;
    bus.byte_last  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      got = load_done;
    end
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL %s_done_timeout: load_done=%b required 1", tag, load_done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({cpu_hold, bus.wr_en, load_done, bus.byte_ready, err_odd, err_ovf} !== 6'b100000 ||
        word_count !== '0) begin
      n_err++;
      $display("FAIL reset_values: hold=%b wr_en=%b done=%b ready=%b odd=%b ovf=%b wc=%0d required 1 0 0 0 0 0 0",
               cpu_hold, bus.wr_en, load_done, bus.byte_ready, err_odd, err_ovf, word_count);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (30) @(negedge clk);
    n_cmp++;
    if ({cpu_hold, bus.wr_en, load_done} !== 3'b100 || obs_q.size() != 0) begin
      n_err++;
      $display("FAIL idle_no_start: hold=%b wr_en=%b done=%b writes=%0d required 1 0 0 0",
               cpu_hold, bus.wr_en, load_done, obs_q.size());
    end
  endtask

  task automatic test_basic(input int gap_max, input string tag);
    logic [7:0] img [4];
    bit ok;
    wr_t e, o;
    int  ne, no;
    img[0] = 8'h70; img[1] = 8'h00; img[2] = 8'h12; img[3] = 8'h34;
    exp_q.delete();
    obs_q.delete();
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      send_byte(img[i], (i == 3), $urandom_range(0, gap_max), ok);
      n_cmp++;
      if (!ok) begin
        n_err++;
        $display("FAIL %s_accept[%0d]: accepted=%b required 1", tag, i, ok);
      end
      if (i == 1) exp_q.push_back({8'h00, 16'h7000});
      if (i == 3) exp_q.push_back({8'h01, 16'h1234});
      if (i == 1 && gap_max == 0) begin
        @(negedge clk);
        n_cmp++;
        if (bus.wr_en !== 1'b1 || bus.byte_ready !== 1'b0) begin
          n_err++;
          $display("FAIL %s_lat_wr: wr_en=%b ready=%b required 1 0", tag, bus.wr_en, bus.byte_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.wr_en !== 1'b0 || bus.byte_ready !== 1'b1) begin
          n_err++;
          $display("FAIL %s_lat_ready: wr_en=%b ready=%b required 0 1", tag, bus.wr_en, bus.byte_ready);
        end
        step();
      end
    end
    for (int a = 2; a < DEPTH; a++) exp_q.push_back({8'(a), 16'h0000});
    wait_done(tag);
    ne = exp_q.size();
    no = obs_q.size();
    n_cmp++;
    if (ne != no) begin
      n_err++;
      $display("FAIL %s_write_count: got %0d writes required %0d", tag, no, ne);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL %s_write: got addr=%h data=%h required addr=%h data=%h", tag, o.addr, o.data, e.addr, e.data);
      end
    end
    n_cmp++;
    if ({cpu_hold, load_done, err_odd, err_ovf} !== 4'b0100 || word_count !== 9'd2) begin
      n_err++;
      $display("FAIL %s_status: hold=%b done=%b odd=%b ovf=%b wc=%0d required 0 1 0 0 2",
               tag, cpu_hold, load_done, err_odd, err_ovf, word_count);
    end
  endtask

  task automatic test_odd();
    bit ok;
    wr_t e, o;
    exp_q.delete();
    obs_q.delete();
    pulse_start();
    send_byte(8'hAB, 1'b1, 0, ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL odd_accept: accepted=%b required 1", ok);
    end
    for (int a = 0; a < DEPTH; a++) exp_q.push_back({8'(a), 16'h0000});
    wait_done("odd");
    n_cmp++;
    if (obs_q.size() != DEPTH) begin
      n_err++;
      $display("FAIL odd_write_count: got %0d writes required %0d", obs_q.size(), DEPTH);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL odd_write: got addr=%h data=%h required addr=%h data=%h", o.addr, o.data, e.addr, e.data);
      end
    end
    n_cmp++;
    if ({cpu_hold, load_done, err_odd, err_ovf} !== 4'b0110 || word_count !== 9'd0) begin
      n_err++;
      $display("FAIL odd_status: hold=%b done=%b odd=%b ovf=%b wc=%0d required 0 1 1 0 0",
               cpu_hold, load_done, err_odd, err_ovf, word_count);
    end
  endtask

  task automatic test_overflow();
    bit ok;
    int rejected = 0;
    int acc_fail = 0;
    logic [7:0] b0, b1;
    wr_t e, o;
    exp_q.delete();
    obs_q.delete();
    pulse_start();
    for (int i = 0; i < 2 * DEPTH; i++) begin
      send_byte(8'(i), 1'b0, 0, ok);
      if (!ok) acc_fail++;
      if (i % 2 == 1) begin
        b0 = 8'(i - 1);
        b1 = 8'(i);
        exp_q.push_back({8'(i / 2), b0, b1});
      end
    end
    n_cmp++;
    if (acc_fail != 0) begin
      n_err++;
      $display("FAIL ovf_accept: %0d bytes refused required 0", acc_fail);
    end
    for (int i = 0; i < 2; i++) begin
      send_byte(8'hEE, (i == 1), 0, ok);
      if (!ok) rejected++;
    end
    n_cmp++;
    if (rejected != 2 || bus.byte_ready !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_excess_bytes: rejected=%0d ready=%b required 2 0", rejected, bus.byte_ready);
    end
    wait_done("ovf");
    n_cmp++;
    if (obs_q.size() != DEPTH) begin
      n_err++;
      $display("FAIL ovf_write_count: got %0d writes required %0d", obs_q.size(), DEPTH);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL ovf_write: got addr=%h data=%h required addr=%h data=%h", o.addr, o.data, e.addr, e.data);
      end
    end
    n_cmp++;
    if ({cpu_hold, load_done, err_odd, err_ovf} !== 4'b0101 || word_count !== 9'd256) begin
      n_err++;
      $display("FAIL ovf_status: hold=%b done=%b odd=%b ovf=%b wc=%0d required 0 1 0 1 256",
               cpu_hold, load_done, err_odd, err_ovf, word_count);
    end
  endtask

  task automatic test_reset_fill();
    logic [7:0] img [4];
    bit ok;
    bit hit = 1'b0;
    wr_t e, o;
    img[0] = 8'h70; img[1] = 8'h00; img[2] = 8'h12; img[3] = 8'h34;
    exp_q.delete();
    obs_q.delete();
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(img[i], (i == 3), 0, ok);
    exp_q.push_back({8'h00, 16'h7000});
    exp_q.push_back({8'h01, 16'h1234});
    for (int a = 2; a <= 8'h40; a++) exp_q.push_back({8'(a), 16'h0000});
    for (int i = 0; i < 500 && !hit; i++) begin
      @(negedge clk);
      hit = (bus.wr_en === 1'b1) && (bus.wr_addr === 8'h40);
    end
    n_cmp++;
    if (!hit) begin
      n_err++;
      $display("FAIL rstfill_reach_40: reached=%b required 1", hit);
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({cpu_hold, bus.wr_en, load_done, bus.byte_ready} !== 4'b1000 ||
        bus.wr_addr !== 8'h00 || word_count !== '0) begin
      n_err++;
      $display("FAIL rstfill_async: hold=%b wr_en=%b done=%b ready=%b addr=%h wc=%0d required 1 0 0 0 00 0",
               cpu_hold, bus.wr_en, load_done, bus.byte_ready, bus.wr_addr, word_count);
    end
    repeat (20) @(negedge clk);
    n_cmp++;
    if (obs_q.size() != 65) begin
      n_err++;
      $display("FAIL rstfill_write_count: got %0d writes required 65", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL rstfill_write: got addr=%h data=%h required addr=%h data=%h", o.addr, o.data, e.addr, e.data);
      end
    end
    step();
    rst = 1'b1;
    test_basic(0, "reload");
  endtask

  initial begin
    bus.byte_in    = 8'h00;
    bus.byte_valid = 1'b0;
    bus.byte_last  = 1'b0;
    test_reset();
    test_basic(0, "basic");
    test_odd();
    test_overflow();
    test_basic(3, "gaps");
    test_reset_fill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
